// File: rtl/seg_pkg.sv
// Segment patterns (active-low {a,b,c,d,e,f,g}), converter state encoding and small helpers
// shared by the seven-segment scan driver and its BCD converter.
package seg_pkg;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per clock, DATA_W steps per conversion.
// done is high during the cycle whose edge performs the final step.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clock_100Mhz,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        if (start) begin
            shift_d = value;
            bcd_d   = '0;
            cnt_d   = CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            bcd_d   = {adj[BCD_W-2:0], shift_q[DATA_W-1]};
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1)) && !start;
    assign bcd  = bcd_q;
endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver with atomic digit commit.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
//   state  | meaning
//   IDLE   | waiting for tick/load/pending request
//   CONV   | double-dabble running, DATA_W cycles
//   COMMIT | digits, overflow and dp mask written to the display register
module seven_segment_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_W       = 16,
    parameter int DIGIT_TICKS  = 262144,
    parameter int UPDATE_TICKS = 100000000
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     displayed_number,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] Anode_Activate,
    output logic [6:0]            LED_out,
    output logic                  dp_out
);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int SCAN_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int UPD_W  = (UPDATE_TICKS > 1) ? $clog2(UPDATE_TICKS) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

    conv_state_t           state_q, state_d;
    logic                  pending_q, pending_d, hex_q, hex_d, ovf_q, ovf_d;
    logic [BCD_W-1:0]      hex_val_q, hex_val_d, dig_c_q, dig_c_d;
    logic [NUM_DIGITS-1:0] dpm_q, dpm_d, dp_c_q, dp_c_d, anode_q, anode_d;
    logic                  ovf_c_q, ovf_c_d, busy_q, busy_d, dpo_q, dpo_d;
    logic [UPD_W-1:0]      upd_cnt_q, upd_cnt_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            led_q, led_d;

    logic             tick, req, ovf_now, conv_start, conv_done, scan_wrap;
    logic [63:0]      num_ext;
    logic [BCD_W-1:0] conv_bcd;
    logic [3:0]       nib, cur_nib;
    logic             blank_i, cur_blank, cur_dp;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic             lz;
`endif

    bin2bcd_seq #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .start        (conv_start),
        .value        (displayed_number),
        .done         (conv_done),
        .bcd          (conv_bcd)
    );

    always_comb begin
        tick       = (UPDATE_TICKS != 0) && (upd_cnt_q == UPD_W'(UPDATE_TICKS - 1));
        upd_cnt_d  = (tick || UPDATE_TICKS == 0) ? '0 : upd_cnt_q + 1'b1;
        req        = tick || load || pending_q;
        num_ext    = 64'(displayed_number);
        ovf_now    = hex_mode ? ((num_ext >> BCD_W) != 64'd0) : (num_ext > DEC_MAX);
        conv_start = 1'b0;
        state_d    = state_q;
        pending_d  = pending_q;
        hex_val_d  = hex_val_q;
        hex_d      = hex_q;
        dpm_d      = dpm_q;
        ovf_d      = ovf_q;
        dig_c_d    = dig_c_q;
        ovf_c_d    = ovf_c_q;
        dp_c_d     = dp_c_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    hex_val_d  = BCD_W'(displayed_number);
                    hex_d      = hex_mode;
                    dpm_d      = dp_mask;
                    ovf_d      = ovf_now;
                    pending_d  = 1'b0;
                    conv_start = !hex_mode && !ovf_now;
                    state_d    = (hex_mode || ovf_now) ? COMMIT : CONV;
                end
            end
            CONV: begin
                if (req) pending_d = 1'b1;
                if (conv_done) state_d = COMMIT;
            end
            COMMIT: begin
                if (req) pending_d = 1'b1;
                dig_c_d = hex_q ? hex_val_q : conv_bcd;
                ovf_c_d = ovf_q;
                dp_c_d  = dpm_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Anode and segment registers both come from idx_q so they always switch together.
    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_W'(DIGIT_TICKS - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_wrap) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        nib       = '0;
        blank_i   = 1'b0;
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        anode_d   = '1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz = 1'b1;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = dig_c_q[4*(NUM_DIGITS-1-i) +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            lz      = lz && (nib == 4'd0);
            blank_i = lz && (i != NUM_DIGITS - 1) && !dp_c_q[i];
`else
            blank_i = 1'b0;
`endif
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = nib;
                cur_dp    = dp_c_q[i];
                cur_blank = blank_i;
                anode_d[NUM_DIGITS-1-i] = 1'b0;
            end
        end
        led_d = ovf_c_q ? SEG_DASH : (cur_blank ? SEG_BLANK : seg_decode(cur_nib));
        dpo_d = ovf_c_q || !cur_dp;
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            hex_val_q  <= '0;
            hex_q      <= 1'b0;
            dpm_q      <= '0;
            ovf_q      <= 1'b0;
            dig_c_q    <= '0;
            ovf_c_q    <= 1'b0;
            dp_c_q     <= '0;
            busy_q     <= 1'b0;
            upd_cnt_q  <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            anode_q    <= '1;
            led_q      <= 7'h7F;
            dpo_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            hex_val_q  <= hex_val_d;
            hex_q      <= hex_d;
            dpm_q      <= dpm_d;
            ovf_q      <= ovf_d;
            dig_c_q    <= dig_c_d;
            ovf_c_q    <= ovf_c_d;
            dp_c_q     <= dp_c_d;
            busy_q     <= busy_d;
            upd_cnt_q  <= upd_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            anode_q    <= anode_d;
            led_q      <= led_d;
            dpo_q      <= dpo_d;
        end
    end

    assign busy           = busy_q;
    assign Anode_Activate = anode_q;
    assign LED_out        = led_q;
    assign dp_out         = dpo_q;
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench: stimulus queues expected frames, a negedge monitor pops one per busy drop
// (or reset release) and checks busy length plus every digit over a full scan rotation.
module tb_seven_segment_scan_driver;
    localparam int ND = 4;
    localparam int DW = 16;
    localparam int DT = 4;

    localparam logic [6:0] T_0 = 7'b0000001, T_1 = 7'b1001111, T_2 = 7'b0010010;
    localparam logic [6:0] T_3 = 7'b0000110, T_4 = 7'b1001100, T_7 = 7'b0001111;
    localparam logic [6:0] T_8 = 7'b0000000, T_9 = 7'b0000100, T_B = 7'b1100000;
    localparam logic [6:0] T_E = 7'b0110000, T_F = 7'b0111000, T_DASH = 7'b1111110;
    localparam logic [6:0] T_BLANK = 7'b1111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] T_LZ = T_BLANK;
`else
    localparam logic [6:0] T_LZ = T_0;
`endif

    typedef struct packed {
        int          blen;
        logic [31:0] segs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, load, hex_mode;
    logic [DW-1:0] num;
    logic [ND-1:0] dpm;
    logic          busy, dp;
    logic [ND-1:0] anode;
    logic [6:0]    led;
    logic          rst2_n, busy2, dp2;
    logic [ND-1:0] anode2;
    logic [6:0]    led2;

    int   n_cmp = 0, n_fail = 0;
    exp_t sb[$];
    exp_t cur;
    int   busy_len = 0, win = 0;
    logic busy_prev = 1'b0, rst_prev = 1'b0, auto_done = 1'b0;
    logic [7:0]    seen [ND];
    logic [ND-1:0] seen_v;
    logic [7:0]    seen2 [ND];
    logic [ND-1:0] seen2_v;

    seven_segment_scan_driver #(.NUM_DIGITS(ND), .DATA_W(DW), .DIGIT_TICKS(DT), .UPDATE_TICKS(0)) u_dut (
        .clock_100Mhz (clk),
        .reset_n      (rst_n),
        .displayed_number (num),
        .load         (load),
        .hex_mode     (hex_mode),
        .dp_mask      (dpm),
        .busy         (busy),
        .Anode_Activate (anode),
        .LED_out      (led),
        .dp_out       (dp)
    );

    seven_segment_scan_driver #(.NUM_DIGITS(ND), .DATA_W(DW), .DIGIT_TICKS(DT), .UPDATE_TICKS(50)) u_auto (
        .clock_100Mhz (clk),
        .reset_n      (rst2_n),
        .displayed_number (16'd1234),
        .load         (1'b0),
        .hex_mode     (1'b0),
        .dp_mask      (4'b0000),
        .busy         (busy2),
        .Anode_Activate (anode2),
        .LED_out      (led2),
        .dp_out       (dp2)
    );

    function automatic exp_t mk(input int blen, input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dm);
        exp_t e;
        e.blen = blen;
        e.segs = {s3, ~dm[3], s2, ~dm[2], s1, ~dm[1], s0, ~dm[0]};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic hx, input logic [3:0] m);
        num = v; hex_mode = hx; dpm = m; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Monitor: a busy drop or reset release means a new frame is on the display.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0; busy_len = 0; win = 0; rst_prev = 1'b0;
        end else begin
            if (win > 0) begin
                for (int i = 0; i < ND; i++) begin
                    if (anode == ~(ND'(1) << (ND - 1 - i))) begin
                        seen[i] = {led, dp}; seen_v[i] = 1'b1;
                    end
                end
                win--;
                if (win == 0) begin
                    for (int i = 0; i < ND; i++) begin
                        n_cmp++;
                        if (!seen_v[i] || seen[i] !== cur.segs[i*8 +: 8]) begin
                            n_fail++;
                            $display("FAIL digit%0d: got seg=%b dp=%b seen=%b want seg=%b dp=%b",
                                     i, seen[i][7:1], seen[i][0], seen_v[i],
                                     cur.segs[i*8+1 +: 7], cur.segs[i*8]);
                        end
                    end
                end
            end
            if (busy) busy_len++;
            if (!rst_prev || (!busy && busy_prev)) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_frame: busy_len=%0d with no queued expectation", busy_len);
                end else begin
                    cur = sb.pop_front();
                    if (cur.blen >= 0) begin
                        n_cmp++;
                        if (busy_len != cur.blen) begin
                            n_fail++;
                            $display("FAIL busy_len: got %0d want %0d", busy_len, cur.blen);
                        end
                    end
                    win = ND * DT;
                    seen_v = '0;
                end
                busy_len = 0;
            end
            busy_prev = busy;
            rst_prev = 1'b1;
        end
    end

    // Auto-capture instance: tick at count 49, capture on the following edge.
    initial begin
        rst2_n = 1'b0;
        tick_n(2);
        rst2_n = 1'b1;
        tick_n(49);
        chk("auto_busy_before_tick", 32'(busy2), 32'd0);
        tick_n(1);
        chk("auto_busy_at_capture", 32'(busy2), 32'd1);
        tick_n(16);
        chk("auto_busy_last_conv", 32'(busy2), 32'd1);
        tick_n(1);
        chk("auto_busy_done", 32'(busy2), 32'd0);
        tick_n(2);
        seen2_v = '0;
        for (int k = 0; k < ND * DT; k++) begin
            for (int i = 0; i < ND; i++) begin
                if (anode2 == ~(ND'(1) << (ND - 1 - i))) begin
                    seen2[i] = {led2, dp2}; seen2_v[i] = 1'b1;
                end
            end
            tick_n(1);
        end
        chk("auto_digit0", {23'd0, seen2_v[0], seen2[0]}, {23'd1, T_1, 1'b1});
        chk("auto_digit1", {23'd0, seen2_v[1], seen2[1]}, {23'd1, T_2, 1'b1});
        chk("auto_digit2", {23'd0, seen2_v[2], seen2[2]}, {23'd1, T_3, 1'b1});
        chk("auto_digit3", {23'd0, seen2_v[3], seen2[3]}, {23'd1, T_4, 1'b1});
        auto_done = 1'b1;
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; hex_mode = 1'b0; num = '0; dpm = '0;
        sb.push_back(mk(-1, T_LZ, T_LZ, T_LZ, T_0, 4'b0000));
        tick_n(3);
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_led", 32'(led), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick_n(25);

        sb.push_back(mk(17, T_9, T_7, T_8, T_9, 4'b0000));
        do_load(16'd9789, 1'b0, 4'b0000);
        tick_n(40);

        sb.push_back(mk(1, T_DASH, T_DASH, T_DASH, T_DASH, 4'b0000));
        do_load(16'd10000, 1'b0, 4'b1111);
        tick_n(25);

        sb.push_back(mk(1, T_B, T_E, T_E, T_F, 4'b1000));
        do_load(16'hBEEF, 1'b1, 4'b1000);
        tick_n(25);

        // Loads during a conversion collapse into one follow-up conversion.
        sb.push_back(mk(17, T_9, T_7, T_8, T_9, 4'b0000));
        sb.push_back(mk(17, T_LZ, T_LZ, T_4, T_2, 4'b0000));
        do_load(16'd9789, 1'b0, 4'b0000);
        tick_n(4);
        do_load(16'd42, 1'b0, 4'b0000);
        tick_n(3);
        do_load(16'd42, 1'b0, 4'b0000);
        tick_n(60);

        sb.push_back(mk(17, T_LZ, T_LZ, T_0, T_7, 4'b0100));
        do_load(16'd7, 1'b0, 4'b0100);
        tick_n(40);

        // Reset in the middle of a conversion: nothing from it may ever reach the display.
        do_load(16'd9789, 1'b0, 4'b0000);
        tick_n(7);
        rst_n = 1'b0;
        #1;
        chk("midrst_anode", 32'(anode), 32'hF);
        chk("midrst_led", 32'(led), 32'h7F);
        chk("midrst_dp", 32'(dp), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        sb.push_back(mk(-1, T_LZ, T_LZ, T_LZ, T_0, 4'b0000));
        tick_n(3);
        rst_n = 1'b1;
        tick_n(60);

        chk("leftover_expectations", 32'(sb.size()), 32'd0);
        for (int k = 0; k < 200 && !auto_done; k++) @(posedge clk);
        chk("auto_process_done", 32'(auto_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
